// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg: shared width and state/owner encodings for the unified memory arbiter.
package riscv_mem_arbiter_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;
endpackage

// File: rtl/riscv_mem_arb_sel.sv
// riscv_mem_arb_sel: combinational grant selector; round-robin on contention when RISCV_MEM_ARB_RR_EN
// is defined, otherwise the data port always wins.
module riscv_mem_arb_sel (
    input  logic i_fetch_req,
    input  logic i_data_req,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_owner
);
    assign o_grant = i_fetch_req | i_data_req;
`ifdef RISCV_MEM_ARB_RR_EN
    assign o_owner = (i_fetch_req & i_data_req) ? ~i_last_grant : i_data_req;
`else
    logic w_unused;
    assign w_unused = i_last_grant;
    assign o_owner  = i_data_req;
`endif
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port memory between fetch and load/store ports with a fixed-latency
// IDLE/ISSUE/WAIT/DONE sequence; RISCV_MEM_ARB_RR_EN selects round-robin arbitration.
module riscv_mem_arbiter #(
    parameter int XLEN    = riscv_mem_arbiter_pkg::XLEN,
    parameter int MEM_LAT = 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_arb_i_req,
    input  logic [XLEN-1:0] i_arb_i_addr,
    output logic            o_arb_i_ack,
    output logic [XLEN-1:0] o_arb_i_rd_data,
    output logic            o_arb_i_stall,
    input  logic            i_arb_d_req,
    input  logic [XLEN-1:0] i_arb_d_addr,
    input  logic            i_arb_d_wr_en,
    input  logic [3:0]      i_arb_d_byte_sel,
    input  logic [XLEN-1:0] i_arb_d_wr_data,
    output logic            o_arb_d_ack,
    output logic [XLEN-1:0] o_arb_d_rd_data,
    output logic            o_arb_d_stall,
    output logic            o_arb_mem_req,
    output logic [XLEN-1:0] o_arb_mem_addr,
    output logic            o_arb_mem_wr_en,
    output logic [3:0]      o_arb_mem_byte_sel,
    output logic [XLEN-1:0] o_arb_mem_wr_data,
    input  logic [XLEN-1:0] i_arb_mem_rd_data
);
    import riscv_mem_arbiter_pkg::*;

    if (MEM_LAT < 1) begin : g_lat_chk
        $error("riscv_mem_arbiter: MEM_LAT must be >= 1");
    end

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    arb_state_t      r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_owner, r_we;
    logic [3:0]      r_bs;
    logic [XLEN-1:0] r_addr, r_wd, r_i_rd, r_d_rd;
    logic            w_grant, w_owner, w_last, w_take, w_issue, w_done, w_cap;

    riscv_mem_arb_sel u_sel (
        .i_fetch_req (i_arb_i_req),
        .i_data_req  (i_arb_d_req),
        .i_last_grant(w_last),
        .o_grant     (w_grant),
        .o_owner     (w_owner)
    );

    assign w_take  = (r_state == ARB_IDLE) & w_grant;
    assign w_issue = r_state == ARB_ISSUE;
    assign w_done  = r_state == ARB_DONE;
    assign w_cap   = (r_state == ARB_WAIT) & (r_cnt == '0);

`ifdef RISCV_MEM_ARB_RR_EN
    logic r_last;
    assign w_last = r_last;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_last <= OWN_FETCH;
        else if (w_take)
            r_last <= w_owner;
    end
`else
    assign w_last = OWN_FETCH;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:  w_next = w_grant ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: w_next = ARB_WAIT;
            ARB_WAIT:  w_next = (r_cnt == '0) ? ARB_DONE : ARB_WAIT;
            default:   w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_owner <= OWN_FETCH;
            r_we    <= 1'b0;
            r_bs    <= 4'h0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_i_rd  <= '0;
            r_d_rd  <= '0;
        end else begin
            r_state <= w_next;
            // Fetch/load lane and write-enable forcing is resolved at latch time.
            if (w_take) begin
                r_owner <= w_owner;
                r_addr  <= (w_owner == OWN_DATA) ? i_arb_d_addr : i_arb_i_addr;
                r_we    <= (w_owner == OWN_DATA) & i_arb_d_wr_en;
                r_bs    <= ((w_owner == OWN_DATA) & i_arb_d_wr_en) ? i_arb_d_byte_sel : 4'hF;
                r_wd    <= ((w_owner == OWN_DATA) & i_arb_d_wr_en) ? i_arb_d_wr_data : '0;
            end
            if (w_issue)
                r_cnt <= LAT_M1;
            else if (r_state == ARB_WAIT && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (w_cap && !r_we && r_owner == OWN_DATA)
                r_d_rd <= i_arb_mem_rd_data;
            if (w_cap && r_owner == OWN_FETCH)
                r_i_rd <= i_arb_mem_rd_data;
        end
    end

    assign o_arb_i_ack        = w_done & (r_owner == OWN_FETCH);
    assign o_arb_d_ack        = w_done & (r_owner == OWN_DATA);
    assign o_arb_i_rd_data    = r_i_rd;
    assign o_arb_d_rd_data    = r_d_rd;
    assign o_arb_i_stall      = i_arb_i_req & ~o_arb_i_ack;
    assign o_arb_d_stall      = i_arb_d_req & ~o_arb_d_ack;
    assign o_arb_mem_req      = w_issue;
    assign o_arb_mem_addr     = w_issue ? r_addr : '0;
    assign o_arb_mem_wr_en    = w_issue & r_we;
    assign o_arb_mem_byte_sel = w_issue ? r_bs : 4'h0;
    assign o_arb_mem_wr_data  = w_issue ? r_wd : '0;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed checks on three arbiter instances with MEM_LAT = 1, 2, 3;
// the memory model returns addr+3, delayed MEM_LAT cycles after each issue.
module tb_riscv_mem_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        i_req [N], d_req [N], d_we [N];
    logic [31:0] i_addr [N], d_addr [N], d_wd [N];
    logic [3:0]  d_bs [N];
    logic        i_ack [N], i_stall [N], d_ack [N], d_stall [N], m_req [N], m_we [N];
    logic [31:0] i_rd [N], d_rd [N], m_addr [N], m_wd [N], m_rd [N];
    logic [3:0]  m_bs [N];

    logic [31:0] pipe [N][N];
    int          nreq [N], dbl [N], both [N];
    bit          prev [N];
    logic [31:0] iss_addr [N], iss_wd [N];
    logic        iss_we [N];
    logic [3:0]  iss_bs [N];

    int n_chk = 0;
    int n_fail = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        riscv_mem_arbiter #(.XLEN(32), .MEM_LAT(g + 1)) u_dut (
            .i_clk(clk), .i_rstn(rstn),
            .i_arb_i_req(i_req[g]), .i_arb_i_addr(i_addr[g]),
            .o_arb_i_ack(i_ack[g]), .o_arb_i_rd_data(i_rd[g]), .o_arb_i_stall(i_stall[g]),
            .i_arb_d_req(d_req[g]), .i_arb_d_addr(d_addr[g]), .i_arb_d_wr_en(d_we[g]),
            .i_arb_d_byte_sel(d_bs[g]), .i_arb_d_wr_data(d_wd[g]),
            .o_arb_d_ack(d_ack[g]), .o_arb_d_rd_data(d_rd[g]), .o_arb_d_stall(d_stall[g]),
            .o_arb_mem_req(m_req[g]), .o_arb_mem_addr(m_addr[g]), .o_arb_mem_wr_en(m_we[g]),
            .o_arb_mem_byte_sel(m_bs[g]), .o_arb_mem_wr_data(m_wd[g]),
            .i_arb_mem_rd_data(m_rd[g])
        );
        assign m_rd[g] = pipe[g][g];
    end

    always @(posedge clk)
        for (int k = 0; k < N; k++) begin
            for (int j = N - 1; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
            pipe[k][0] <= m_req[k] ? m_addr[k] + 32'h3 : 32'hBAD0_BAD0;
        end

    always @(negedge clk)
        for (int k = 0; k < N; k++) begin
            if (m_req[k]) begin
                nreq[k]++;
                iss_addr[k] = m_addr[k];
                iss_we[k]   = m_we[k];
                iss_bs[k]   = m_bs[k];
                iss_wd[k]   = m_wd[k];
            end
            if (m_req[k] && prev[k]) dbl[k]++;
            if (i_ack[k] && d_ack[k]) both[k]++;
            prev[k] = m_req[k];
        end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] outs(input int k);
        return {i_ack[k], i_rd[k], i_stall[k], d_ack[k], d_rd[k], d_stall[k],
                m_req[k], m_addr[k], m_we[k], m_bs[k], m_wd[k]};
    endfunction

    task automatic go(input int k, input bit dport, input logic [31:0] a, input bit we,
                      input logic [3:0] bs, input logic [31:0] wd, output int lat, output int st);
        @(posedge clk); #1;
        if (dport) begin
            d_req[k] = 1'b1; d_addr[k] = a; d_we[k] = we; d_bs[k] = bs; d_wd[k] = wd;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = a;
        end
        lat = -1;
        st = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (dport ? d_stall[k] : i_stall[k]) st++;
            if (dport ? d_ack[k] : i_ack[k]) begin
                lat = n;
                break;
            end
        end
        @(posedge clk); #1;
        d_req[k] = 1'b0;
        i_req[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st, s0, dc, ic, nack, last;
        bit da, ia;
        logic [3:0] seq;
        for (int k = 0; k < N; k++) begin
            i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_addr[k] = 0;
            d_we[k] = 0; d_bs[k] = 0; d_wd[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) chk($sformatf("reset_outs%0d", k), outs(k), '0);
        rstn = 1'b1;

        s0 = nreq[0];
        go(0, 0, 32'h10, 0, 4'h0, 32'h0, lat, st);
        chk("fetch_lat", lat, 3);
        chk("fetch_stall_cycles", st, 3);
        chk("fetch_memreq_count", nreq[0] - s0, 1);
        chk("fetch_mem_addr", iss_addr[0], 32'h10);
        chk("fetch_mem_we", iss_we[0], 1'b0);
        chk("fetch_mem_bs", iss_bs[0], 4'hF);
        chk("fetch_rd", i_rd[0], 32'h13);

        s0 = nreq[0];
        go(0, 1, 32'h100, 1, 4'b0011, 32'hDEAD_BEEF, lat, st);
        chk("store_lat", lat, 3);
        chk("store_memreq_count", nreq[0] - s0, 1);
        chk("store_mem_addr", iss_addr[0], 32'h100);
        chk("store_mem_we", iss_we[0], 1'b1);
        chk("store_mem_bs", iss_bs[0], 4'b0011);
        chk("store_mem_wd", iss_wd[0], 32'hDEAD_BEEF);
        chk("store_d_rd_kept", d_rd[0], 32'h0);

        go(2, 1, 32'h200, 0, 4'b0001, 32'h0, lat, st);
        chk("load3_lat", lat, 5);
        chk("load3_rd", d_rd[2], 32'h203);
        chk("load3_mem_bs", iss_bs[2], 4'hF);
        chk("load3_mem_we", iss_we[2], 1'b0);

        go(0, 1, 32'h44, 0, 4'h0, 32'h0, lat, st);
        chk("load1_rd", d_rd[0], 32'h47);
        chk("fetch_rd_held", i_rd[0], 32'h13);
        go(1, 0, 32'h50, 0, 4'h0, 32'h0, lat, st);
        chk("fetch2_lat", lat, 4);
        chk("fetch2_rd", i_rd[1], 32'h53);

        // Simultaneous requests on the MEM_LAT=2 instance.
        s0 = nreq[1];
        @(posedge clk); #1;
        i_req[1] = 1; i_addr[1] = 32'h80;
        d_req[1] = 1; d_addr[1] = 32'h90; d_we[1] = 0; d_bs[1] = 0;
        dc = -1; ic = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            da = d_ack[1]; ia = i_ack[1];
            if (da) dc = n;
            if (ia) ic = n;
            @(posedge clk); #1;
            if (da) d_req[1] = 0;
            if (ia) i_req[1] = 0;
            if (dc >= 0 && ic >= 0) break;
        end
        d_req[1] = 0; i_req[1] = 0;
        chk("both_data_ack_cycle", dc, 4);
        chk("both_fetch_ack_cycle", ic, 9);
        chk("both_memreq_count", nreq[1] - s0, 2);
        chk("both_d_rd", d_rd[1], 32'h93);
        chk("both_i_rd", i_rd[1], 32'h83);

        // Both requests held through four transactions.
        @(posedge clk); #1;
        i_req[1] = 1; i_addr[1] = 32'h400;
        d_req[1] = 1; d_addr[1] = 32'h300; d_we[1] = 0; d_bs[1] = 0;
        seq = 4'h0; nack = 0; last = -1;
        for (int n = 0; n < 60 && nack < 4; n++) begin
            @(negedge clk);
            if (d_ack[1] || i_ack[1]) begin
                seq = {seq[2:0], d_ack[1]};
                nack++;
                last = n;
            end
        end
        @(posedge clk); #1;
        i_req[1] = 0; d_req[1] = 0;
`ifdef RISCV_MEM_ARB_RR_EN
        chk("held_grant_order", seq, 4'b1010);
`else
        chk("held_grant_order", seq, 4'b1111);
`endif
        chk("held_last_ack_cycle", last, 19);
        repeat (3) @(posedge clk);

        // Reset asserted while the MEM_LAT=3 instance sits in WAIT.
        @(posedge clk); #1;
        i_req[2] = 1; i_addr[2] = 32'h20;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b0;
        i_req[2] = 0;
        #1;
        chk("rst_wait_outs", outs(2), '0);
        chk("rst_other_rd", i_rd[0], 32'h0);
        nack = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (i_ack[2] || d_ack[2]) nack++;
        end
        chk("rst_no_ack", nack, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        go(2, 0, 32'h30, 0, 4'h0, 32'h0, lat, st);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_rd", i_rd[2], 32'h33);

        chk("no_dual_ack", both[0] + both[1] + both[2], 0);
        chk("memreq_single_cycle", dbl[0] + dbl[1] + dbl[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
